// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scans a 4x4 matrix keypad one row at a time. It debounces the press and the
// release of a single key and reports each new key once, as a hex code.
//
// While a key is being debounced or held, the row drive stays frozen on the
// key's row. Only the key's own column is watched, so other keys are locked
// out. A held key never repeats.
//
// Parameters
//   SETTLE    cycles each row is driven before its columns are sampled (>= 2)
//   DEBOUNCE  press / release debounce window in clk cycles (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   col[3:0]   synchronized column sense, 1 = closed contact on the driven row
//   row[3:0]   one-hot, active-high row drive
//   key_valid  one-cycle pulse for a debounced new key press
//   key_code   hex code of the last valid key, held between pulses
//   busy       high whenever the scanner is not in SCAN
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SETTLE   = 16,
    parameter int DEBOUNCE = 6000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       busy
);

    localparam int SW = $clog2(SETTLE);
    localparam int DW = $clog2(DEBOUNCE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [DW-1:0] db_cnt;
    logic [1:0]    r_idx;
    logic [1:0]    c_idx;

    logic       col_single;
    logic [1:0] col_idx;
    logic [1:0] row_idx;
    logic       col_hit;
    logic [3:0] row_next;

    // Keymap: r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: E 0 F D
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Sample decode. A column pattern counts as a key only when exactly one
    // bit is set; two or more contacts on one row are treated as no key.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the case statements leaves it unassigned (latch).
        col_single = 1'b0;
        col_idx    = 2'd0;
        row_idx    = 2'd0;
        case (col)
            4'b0001: begin col_single = 1'b1; col_idx = 2'd0; end
            4'b0010: begin col_single = 1'b1; col_idx = 2'd1; end
            4'b0100: begin col_single = 1'b1; col_idx = 2'd2; end
            4'b1000: begin col_single = 1'b1; col_idx = 2'd3; end
            default: begin col_single = 1'b0; col_idx = 2'd0; end
        endcase
        case (row)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    assign col_hit  = col[c_idx];
    assign row_next = {row[2:0], row[3]};

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments, so every
        // right-hand side sees the values from before this edge.
        if (reset) begin
            state      <= SCAN;
            row        <= 4'b0001;
            key_valid  <= 1'b0;
            key_code   <= 4'h0;
            busy       <= 1'b0;
            settle_cnt <= '0;
            db_cnt     <= '0;
            r_idx      <= 2'd0;
            c_idx      <= 2'd0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        if (col_single) begin
                            r_idx  <= row_idx;
                            c_idx  <= col_idx;
                            db_cnt <= '0;
                            busy   <= 1'b1;
                            state  <= PRESS_DB;
                        end else begin
                            row <= row_next;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end

                PRESS_DB: begin
                    if (!col_hit) begin
                        // Bounce or glitch: give up silently and resume on the next row.
                        row        <= row_next;
                        settle_cnt <= '0;
                        busy       <= 1'b0;
                        state      <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key_valid <= 1'b1;
                        key_code  <= key_map(r_idx, c_idx);
                        state     <= HELD;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end

                HELD: begin
                    if (!col_hit) begin
                        db_cnt <= '0;
                        state  <= RELEASE_DB;
                    end
                end

                RELEASE_DB: begin
                    if (col_hit) begin
                        // Contact came back: restart the release window.
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        row        <= row_next;
                        settle_cnt <= '0;
                        busy       <= 1'b0;
                        state      <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Bench for keypad_scan_ctrl with SETTLE=4 and DEBOUNCE=10. A physical keypad
// model turns a 16-bit "pressed keys" mask and the current row drive into
// col. Cycle k is the interval after the k-th rising edge following reset.
// Outputs are sampled on the falling edge.
//
// Expected values come from plain arithmetic on the scan timing:
//   - A row slot lasts S cycles.
//   - A key in row r is sampled at the end of slot r.
//   - The press pulse comes D+1 cycles after that sample.
//   - SCAN resumes D+1 cycles after the last cycle on which the contact was
//     closed during release.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    localparam int S = 4;
    localparam int D = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col = 4'b0000;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       busy;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] mask   = 16'h0;   // bit r*4+c = key at (r,c) is pressed

    logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

    logic [9:0] obs;
    logic [9:0] exp_v;
    logic [3:0] er;

    keypad_scan_ctrl #(.SETTLE(S), .DEBOUNCE(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Matrix keypad: a column reads 1 if any pressed key on a driven row sits in it.
    function automatic logic [3:0] keypad_col(input logic [3:0] r, input logic [15:0] m);
        logic [3:0] c;
        c = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (r[i]) c = c | m[i*4 +: 4];
        return c;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v;
        v = 4'b0001 << (idx % 4);
        return v;
    endfunction

    // Present col for the current cycle, then advance to the next cycle.
    task automatic step();
        col = keypad_col(row, mask);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mask  = 16'h0;
        col   = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        obs   = {row, key_valid, key_code, busy};
        exp_v = {4'b0001, 1'b0, 4'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got row=%b kv=%b code=%h busy=%b, expected row=%b kv=%b code=%h busy=%b",
                     obs[9:6], obs[5], obs[4:1], obs[0], exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
        end
    endtask

    task automatic test_idle_scan();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            er    = onehot(cyc / S);
            obs   = {row, key_valid, key_code, busy};
            exp_v = {er, 1'b0, 4'h0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL idle_scan cyc=%0d: got row=%b kv=%b code=%h busy=%b, expected row=%b kv=%b code=%h busy=%b",
                         cyc, obs[9:6], obs[5], obs[4:1], obs[0], exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
            end
            step();
        end
    endtask

    // Random key: press, hold (with a second key on the same row pressed too),
    // then release with two bounces.
    task automatic test_press_random(input int iters);
        int r, c, c2, samp, pulse, rel, b1, b2, scan_at;
        logic [3:0] key;
        for (int it = 0; it < iters; it++) begin
            r       = int'($urandom_range(3, 0));
            c       = int'($urandom_range(3, 0));
            c2      = (c + 1) % 4;
            key     = km[r*4 + c];
            samp    = r*S + S - 1;
            pulse   = samp + 1 + D;
            rel     = pulse + 20;
            b1      = rel + int'($urandom_range(4, 1));
            b2      = b1 + int'($urandom_range(6, 1));
            scan_at = b2 + D + 1;
            do_reset();
            while (cyc <= scan_at + 2*S) begin
                mask = 16'h0;
                if (cyc < rel || cyc == b1 || cyc == b2) mask[r*4 + c] = 1'b1;
                if (cyc >= pulse + 3 && cyc < rel)      mask[r*4 + c2] = 1'b1;
                if (cyc <= samp)        er = onehot(cyc / S);
                else if (cyc < scan_at) er = onehot(r);
                else                    er = onehot(r + 1 + (cyc - scan_at) / S);
                obs   = {row, key_valid, key_code, busy};
                exp_v = {er, (cyc == pulse), (cyc >= pulse) ? key : 4'h0, (cyc > samp && cyc < scan_at)};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL press_r%0dc%0d cyc=%0d: got row=%b kv=%b code=%h busy=%b, expected row=%b kv=%b code=%h busy=%b",
                             r, c, cyc, obs[9:6], obs[5], obs[4:1], obs[0], exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
                end
                step();
            end
        end
    endtask

    // Key (0,0) drops for one cycle at debounce count 5, then is pressed stably.
    task automatic test_press_abort();
        do_reset();
        while (cyc <= 45) begin
            mask = (cyc == 9) ? 16'h0 : 16'h0001;
            if (cyc < 10)      er = 4'b0001;
            else if (cyc < 26) er = onehot((cyc - 10) / S + 1);
            else               er = 4'b0001;
            obs   = {row, key_valid, key_code, busy};
            exp_v = {er, (cyc == 36), (cyc >= 36) ? 4'h1 : 4'h0,
                     ((cyc >= 4 && cyc < 10) || cyc >= 26)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL press_abort cyc=%0d: got row=%b kv=%b code=%h busy=%b, expected row=%b kv=%b code=%h busy=%b",
                         cyc, obs[9:6], obs[5], obs[4:1], obs[0], exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
            end
            step();
        end
    endtask

    // Two contacts on row 3 give col=0011 at the row-3 sample; the sample is ignored.
    task automatic test_multi_col();
        do_reset();
        while (cyc < 40) begin
            mask  = 16'h3000;
            er    = onehot(cyc / S);
            obs   = {row, key_valid, key_code, busy};
            exp_v = {er, 1'b0, 4'h0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL multi_col cyc=%0d: got row=%b kv=%b code=%h busy=%b, expected row=%b kv=%b code=%h busy=%b",
                         cyc, obs[9:6], obs[5], obs[4:1], obs[0], exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
            end
            step();
        end
    endtask

    // Key 6 is accepted and released. Key 1 is then pressed, and reset is
    // asserted when its press debounce reaches count D-1.
    task automatic test_reset_mid_debounce();
        do_reset();
        while (cyc <= 58) begin
            if (cyc < 25)      mask = 16'h0040;
            else if (cyc < 36) mask = 16'h0000;
            else               mask = 16'h0001;
            if (cyc <= 7)       er = onehot(cyc / S);
            else if (cyc < 36)  er = 4'b0010;
            else if (cyc < 48)  er = onehot(2 + (cyc - 36) / S);
            else                er = 4'b0001;
            obs   = {row, key_valid, key_code, busy};
            exp_v = {er, (cyc == 18), (cyc >= 18 && cyc < 58) ? 4'h6 : 4'h0,
                     ((cyc >= 8 && cyc < 36) || (cyc >= 48 && cyc < 58))};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_db cyc=%0d: got row=%b kv=%b code=%h busy=%b, expected row=%b kv=%b code=%h busy=%b",
                         cyc, obs[9:6], obs[5], obs[4:1], obs[0], exp_v[9:6], exp_v[5], exp_v[4:1], exp_v[0]);
            end
            if (cyc == 57) reset = 1'b1;
            if (cyc == 58) reset = 1'b0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_random(8);
        test_press_abort();
        test_multi_col();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
